// File: rtl/nes_pad_sampler_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | nes_pad_pkg : shared types and constants for the NES pad sampler        |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package nes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4,
        EMIT  = 3'd5
    } state_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int KEEPALIVE_POLLS = 30;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nes_pad_sampler_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | nes_pad_sampler_if : redundant-word stream towards network_stack_tx     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface nes_pad_sampler_if #(
    parameter int DATA_SIZE = 16
);
    logic                 axiov;
    logic [DATA_SIZE-1:0] axiod;

    modport master (output axiov, output axiod);
    modport slave  (input  axiov, input  axiod);
endinterface
`default_nettype wire

// File: rtl/nes_pad_sampler_sync_2ff.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer, async active-low reset                |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/nes_pad_sampler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | nes_pad_sampler : polls an NES pad and bursts {buttons,buttons} words   |
// | Option: NES_PAD_CHANGE_ONLY_EN (burst only on change or keepalive)      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module nes_pad_sampler
    import nes_pad_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int POLL_HZ      = 60,
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int WORDS        = 6,
    parameter int DATA_SIZE    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         enable,
    input  wire logic         pad_data,
    output logic              pad_latch,
    output logic              pad_pulse,
    output logic [7:0]        buttons,
    output logic              sample_done,
    nes_pad_sampler_if.master tx
);
    localparam int P       = CLK_HZ / POLL_HZ;
    localparam int SEQ_LEN = LATCH_CYCLES + 16 * HALF_CYCLES + 1 + WORDS;
    localparam int POLL_W  = $clog2(P + 1);
    localparam int CNT_W   = $clog2(max3(LATCH_CYCLES, HALF_CYCLES, WORDS) + 1);

    state_e            r_state;
    state_e            w_next;
    logic [POLL_W-1:0] r_poll;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_k;
    logic [7:0]        r_shift;
    logic [7:0]        r_buttons;
    logic [15:0]       r_axiod;
    logic              w_sync;
    logic              w_bit;
    logic              w_tick;
    logic              w_latch_end;
    logic              w_half_end;
    logic              w_emit_end;
    logic              w_send;
    logic              w_pad_latch;
    logic              w_pad_pulse;
    logic              w_axiov;
    logic              w_sample_done;

    // Idle line is high (nothing pressed), so the synchronizer resets to 1.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_pad (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pad_data),
        .o_q   (w_sync)
    );

    assign w_bit = ~w_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poll <= '0;
        end else if (w_tick) begin
            r_poll <= '0;
        end else begin
            r_poll <= r_poll + 1'b1;
        end
    end

    assign w_tick      = (r_poll == POLL_W'(P - 1));
    assign w_latch_end = (r_cnt == CNT_W'(LATCH_CYCLES - 1));
    assign w_half_end  = (r_cnt == CNT_W'(HALF_CYCLES - 1));
    assign w_emit_end  = (r_cnt == CNT_W'(WORDS - 1));

`ifdef NES_PAD_CHANGE_ONLY_EN
    localparam int KEEP_W = $clog2(KEEPALIVE_POLLS + 1);

    logic [7:0]        r_last_sent;
    logic [KEEP_W-1:0] r_keep;

    // r_keep counts earlier burst-less polls; the current poll makes it 30.
    assign w_send = (r_shift != r_last_sent) ||
                    (r_keep >= KEEP_W'(KEEPALIVE_POLLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sent <= '0;
            r_keep      <= '0;
        end else begin
            if (r_state == EMIT) begin
                r_last_sent <= r_shift;
            end
            if (r_state == DONE) begin
                if (w_send) begin
                    r_keep <= '0;
                end else if (r_keep != KEEP_W'(KEEPALIVE_POLLS - 1)) begin
                    r_keep <= r_keep + 1'b1;
                end
            end
        end
    end
`else
    assign w_send = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_pad_latch   = 1'b0;
        w_pad_pulse   = 1'b0;
        w_axiov       = 1'b0;
        w_sample_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick && enable) begin
                    w_next = LATCH;
                end
            end
            LATCH: begin
                w_pad_latch = 1'b1;
                if (w_latch_end) begin
                    w_next = LOW;
                end
            end
            LOW: begin
                if (w_half_end) begin
                    w_next = HIGH;
                end
            end
            HIGH: begin
                w_pad_pulse = 1'b1;
                if (w_half_end) begin
                    w_next = (r_k == 3'd7) ? DONE : LOW;
                end
            end
            DONE: begin
                w_sample_done = 1'b1;
                w_next        = w_send ? EMIT : IDLE;
            end
            EMIT: begin
                w_axiov = 1'b1;
                if (w_emit_end) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Per-state cycle counter; restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // buttons loads on entry to DONE so it changes together with sample_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k       <= '0;
            r_shift   <= '0;
            r_buttons <= '0;
            r_axiod   <= '0;
        end else begin
            if (r_state == IDLE && w_next == LATCH) begin
                r_k <= '0;
            end
            if (r_state == HIGH && w_half_end && r_k != 3'd7) begin
                r_k <= r_k + 1'b1;
            end
            if (r_state == LOW && w_half_end) begin
                r_shift[r_k] <= w_bit;
            end
            if (r_state == HIGH && w_next == DONE) begin
                r_buttons <= r_shift;
            end
            if (r_state == DONE && w_next == EMIT) begin
                r_axiod <= {r_shift, r_shift};
            end
        end
    end

    assign pad_latch   = w_pad_latch;
    assign pad_pulse   = w_pad_pulse;
    assign sample_done = w_sample_done;
    assign buttons     = r_buttons;
    assign tx.axiov    = w_axiov;
    assign tx.axiod    = r_axiod;

    a_seq_fits:  assert property (@(posedge clk) SEQ_LEN < P);
    a_words_min: assert property (@(posedge clk) WORDS >= 1);
    a_data_size: assert property (@(posedge clk) DATA_SIZE == 16);

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_sampler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_nes_pad_sampler : directed bench with an NES pad shift-register model|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_nes_pad_sampler;

    typedef struct {
        logic [7:0]  btn;
        logic [7:0]  exp_btn;
        logic [15:0] exp_d;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_pulse;
    logic       sample_done;
    logic [7:0] buttons;

    logic [7:0] pad_btn = 8'h00;
    int         idx = 0;
    logic       pulse_d = 1'b0;
    logic       use_model = 1'b1;
    logic       rnd_data = 1'b1;
    logic       rnd_run = 1'b0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    nes_pad_sampler_if #(.DATA_SIZE(16)) tx_if ();

    nes_pad_sampler #(
        .CLK_HZ       (1000),
        .POLL_HZ      (10),
        .LATCH_CYCLES (4),
        .HALF_CYCLES  (2),
        .WORDS        (6),
        .DATA_SIZE    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pad_data    (pad_data),
        .pad_latch   (pad_latch),
        .pad_pulse   (pad_pulse),
        .buttons     (buttons),
        .sample_done (sample_done),
        .tx          (tx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 4021-style pad: latch reloads, each pulse rising edge advances one bit.
    always @(posedge clk) begin
        pulse_d <= pad_pulse;
        if (pad_latch) begin
            idx <= 0;
        end else if (pad_pulse && !pulse_d) begin
            idx <= idx + 1;
        end
    end

    assign pad_data = use_model ? ((idx < 8) ? ~pad_btn[idx[2:0]] : 1'b0) : rnd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_latch(input string tag, output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (pad_latch === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        chk({tag, "_latch_seen"}, {31'd0, ok}, 32'd1);
    endtask

    // Called at the negedge where pad_latch was first seen high (offset 0).
    task automatic observe_poll(input string tag, input logic [7:0] exp_btn,
                                input logic [15:0] exp_d, input bit exp_burst);
        int e_latch, e_pulse, e_sd, e_v, e_d, nwords;
        logic [7:0] btn_at_done;
        bit exp_p, exp_v;
        e_latch = 0; e_pulse = 0; e_sd = 0; e_v = 0; e_d = 0; nwords = 0;
        btn_at_done = 8'hxx;
        for (int off = 0; off < 50; off++) begin
            if (off > 0) @(negedge clk);
            exp_p = (off >= 4) && (off < 36) && (((off - 4) % 4) >= 2);
            exp_v = exp_burst && (off >= 37) && (off < 43);
            if (pad_latch !== (off < 4)) e_latch++;
            if (pad_pulse !== exp_p) e_pulse++;
            if (sample_done !== (off == 36)) e_sd++;
            if (tx_if.axiov !== exp_v) e_v++;
            if (tx_if.axiov === 1'b1) begin
                nwords++;
                if (tx_if.axiod !== exp_d) e_d++;
            end
            if (off == 36) btn_at_done = buttons;
        end
        chk({tag, "_latch_wave_errs"}, e_latch, 0);
        chk({tag, "_pulse_wave_errs"}, e_pulse, 0);
        chk({tag, "_sample_done_errs"}, e_sd, 0);
        chk({tag, "_axiov_errs"}, e_v, 0);
        chk({tag, "_axiod_errs"}, e_d, 0);
        chk({tag, "_words"}, nwords, exp_burst ? 6 : 0);
        chk({tag, "_buttons"}, {24'd0, btn_at_done}, {24'd0, exp_btn});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int t, t0, tprev, ten;
        int nlatch, xerr, herr, words;
        bit exp_b;

        vecs[0] = '{btn: 8'h09, exp_btn: 8'h09, exp_d: 16'h0909};
        vecs[1] = '{btn: 8'hFF, exp_btn: 8'hFF, exp_d: 16'hFFFF};
        vecs[2] = '{btn: 8'h00, exp_btn: 8'h00, exp_d: 16'h0000};
        vecs[3] = '{btn: 8'h80, exp_btn: 8'h80, exp_d: 16'h8080};
        vecs[4] = '{btn: 8'h55, exp_btn: 8'h55, exp_d: 16'h5555};
        vecs[5] = '{btn: 8'hA6, exp_btn: 8'hA6, exp_d: 16'hA6A6};

        // Reset state
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pad_latch", {31'd0, pad_latch}, 0);
        chk("rst_pad_pulse", {31'd0, pad_pulse}, 0);
        chk("rst_axiov", {31'd0, tx_if.axiov}, 0);
        chk("rst_axiod", {16'd0, tx_if.axiod}, 0);
        chk("rst_buttons", {24'd0, buttons}, 0);
        chk("rst_sample_done", {31'd0, sample_done}, 0);
        rst_n = 1'b1;

        // Table of snapshots, back-to-back polls
        tprev = 0;
        for (int i = 0; i < 6; i++) begin
            pad_btn = vecs[i].btn;
            wait_latch($sformatf("vec%0d", i), t);
            if (i == 1) chk("poll_period", t - tprev, 100);
            tprev = t;
            observe_poll($sformatf("vec%0d", i), vecs[i].exp_btn, vecs[i].exp_d, 1'b1);
        end

        // enable dropped during LATCH: that poll completes, then silence
        pad_btn = 8'h3C;
        wait_latch("en", t0);
        enable = 1'b0;
        observe_poll("en_off", 8'h3C, 16'h3C3C, 1'b1);
        nlatch = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (pad_latch !== 1'b0) nlatch++;
        end
        chk("en_off_no_latch", nlatch, 0);
        pad_btn = 8'hC3;
        enable  = 1'b1;
        ten     = cyc;
        wait_latch("en_on", t);
        chk("en_on_tick_aligned", (t - t0) % 100, 0);
        chk("en_on_first_tick", {31'd0, (t - ten) <= 100}, 1);
        observe_poll("en_on", 8'hC3, 16'hC3C3, 1'b1);

        // Reset pulse during burst word 3
        pad_btn = 8'h5A;
        wait_latch("rst_mid", t);
        repeat (39) @(negedge clk);
        chk("rst_mid_inburst", {31'd0, tx_if.axiov}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_axiov", {31'd0, tx_if.axiov}, 0);
        chk("rst_mid_latch", {31'd0, pad_latch}, 0);
        chk("rst_mid_pulse", {31'd0, pad_pulse}, 0);
        chk("rst_mid_buttons", {24'd0, buttons}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pad_btn = 8'hA5;
        wait_latch("after_rst", t);
        observe_poll("after_rst", 8'hA5, 16'hA5A5, 1'b1);

        // Constant buttons across many polls
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pad_btn = 8'h10;
`ifdef NES_PAD_CHANGE_ONLY_EN
        for (int p = 1; p <= 31; p++) begin
            exp_b = (p == 1) || (p == 31);
            wait_latch($sformatf("keep%0d", p), t);
            observe_poll($sformatf("keep%0d", p), 8'h10, 16'h1010, exp_b);
        end
        pad_btn = 8'h20;
        wait_latch("change", t);
        observe_poll("change", 8'h20, 16'h2020, 1'b1);
`else
        for (int p = 1; p <= 3; p++) begin
            exp_b = 1'b1;
            wait_latch($sformatf("const%0d", p), t);
            observe_poll($sformatf("const%0d", p), 8'h10, 16'h1010, exp_b);
        end
`endif

        // Free-running asynchronous data, no pad model
        use_model = 1'b0;
        rnd_run   = 1'b1;
        fork
            begin
                while (rnd_run) begin
                    #($urandom_range(1, 37));
                    rnd_data = ~rnd_data;
                end
            end
        join_none
        xerr = 0; herr = 0; words = 0;
        for (int p = 0; p < 3; p++) begin
            wait_latch($sformatf("rnd%0d", p), t);
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if ($isunknown({pad_latch, pad_pulse, buttons, sample_done,
                                tx_if.axiov, tx_if.axiod})) xerr++;
                if (tx_if.axiov === 1'b1) begin
                    words++;
                    if (tx_if.axiod[15:8] !== tx_if.axiod[7:0]) herr++;
                end
            end
        end
        rnd_run = 1'b0;
        chk("rnd_no_x", xerr, 0);
        chk("rnd_byte_pair", herr, 0);
`ifndef NES_PAD_CHANGE_ONLY_EN
        chk("rnd_words", words, 18);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nes_pad_sampler.md
Name: nes_pad_sampler

Overview:
- Upstream feeder for the network TX stack: polls a physical NES controller over its latch/pulse/data wires and reads 8 button bits.
- Streams each snapshot as a burst of redundant 16-bit words {buttons, buttons} into network_stack_tx. The far end's majority vote and byte-pair check consume exactly this format.
- Runs in the 50 MHz eth_refclk domain.

Parameters:
- CLK_HZ, 50_000_000, clock frequency in Hz.
- POLL_HZ, 60, controller poll rate. Poll period is P = CLK_HZ/POLL_HZ cycles.
- LATCH_CYCLES, 600, width of the pad_latch high pulse (12 us at 50 MHz).
- HALF_CYCLES, 300, length of each pad_pulse low phase and each high phase (6 us).
- WORDS, 6, number of words per burst. Must be ≥1.
- DATA_SIZE, 16, axiod width. Fixed at 2×8.

Ports:
- clk, in, 1, eth_refclk.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, allows new polls to start.
- pad_data, in, 1, controller serial data. Active-low: 0 = pressed. Asynchronous to clk.
- pad_latch, out, 1, controller latch strobe.
- pad_pulse, out, 1, controller clock.
- axiov, out, 1, burst word valid, to network_stack_tx axiiv.
- axiod, out, 16, burst word, to network_stack_tx axiid.
- buttons, out, 8, last completed snapshot. Active-high.
- sample_done, out, 1, one-cycle strobe when buttons updates.

Behaviour:
- Reset (async assert, sync release):
  - pad_latch=0, pad_pulse=0, axiov=0, axiod=0, buttons=0, sample_done=0.
  - state=IDLE, poll counter=0, last_sent=0.
- Input conditioning: pad_data passes through a 2-flop synchronizer. Inside this block "bit" means the synchronized value, inverted.
- Poll timer:
  - Free-running counter 0..P-1. tick=1 when the count is P-1.
  - Runs regardless of enable and state.
- A tick that arrives while state≠IDLE or enable=0 is dropped. There is no queuing.
- Button bit mapping: buttons[0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- State machine:
  - IDLE: on tick && enable, go to LATCH and clear bit index k=0.
  - LATCH:
    - pad_latch=1 for exactly LATCH_CYCLES cycles, starting the cycle after the tick.
    - Then go to LOW.
  - LOW:
    - pad_latch=0, pad_pulse=0 for HALF_CYCLES cycles.
    - On the last LOW cycle, shift[k] ← bit.
    - Then go to HIGH.
  - HIGH:
    - pad_pulse=1 for HALF_CYCLES cycles.
    - Then, if k==7, go to DONE; otherwise k++ and go to LOW.
    - 8 pulses are issued in total.
  - DONE (1 cycle): buttons ← shift, sample_done=1. Go to EMIT, or to IDLE when the optional feature suppresses the burst.
  - EMIT:
    - axiov=1 and axiod={shift,shift} for exactly WORDS consecutive cycles; last_sent ← shift.
    - Then axiov=0 and go to IDLE.
    - axiov never drops mid-burst and is never asserted outside EMIT.
- Sequence length: one poll occupies LATCH_CYCLES + 16·HALF_CYCLES + 1 + WORDS cycles. This must be < P; this is a static requirement, checked by a simulation assertion.
- enable deasserted mid-sequence: the sequence and its burst complete normally. Further ticks are then ignored.
- rst_n asserted mid-sequence or mid-burst: all outputs drop immediately and asynchronously. No partial burst is resumed.
- axiod holds its last value when axiov=0. Consumers must qualify it with axiov.

Optional Feature:
- Macro NES_PAD_CHANGE_ONLY_EN.
- Defined:
  - DONE goes to EMIT only if shift≠last_sent, or if 30 consecutive polls have completed without a burst (keepalive).
  - The keepalive counter clears on every burst.
  - buttons and sample_done still update on every poll.
- Undefined: every completed poll emits a burst.

Decomposition:
- Package nes_pad_pkg:
  - State enum (IDLE, LATCH, LOW, HIGH, DONE, EMIT).
  - Button index localparams (BTN_A..BTN_RIGHT).
  - KEEPALIVE_POLLS = 30.
- Sub-module sync_2ff: generic 2-flop synchronizer with the same clk/rst_n convention. Instantiate it once for pad_data.

Test Plan (sim params CLK_HZ=1000, POLL_HZ=10 → P=100; LATCH_CYCLES=4, HALF_CYCLES=2, WORDS=6):
1. Pad model holds A and Start pressed (pad_data low on bit slots 0 and 3) → buttons=8'h09, sample_done pulses once. Then 6 cycles of axiov with axiod=16'h0909.
2. Waveform timing from the tick → pad_latch high exactly 4 cycles. Then 8 pad_pulse highs of 2 cycles each, separated by 2-cycle lows. The burst starts 38 cycles after the tick. Next poll starts 100 cycles after the first.
3. enable=0 during a poll's LATCH phase → that poll and its burst complete. No further pad_latch activity until enable=1, then the first poll starts on the next tick.
4. rst_n pulsed low during EMIT word 3 → axiov, pad_latch, pad_pulse and buttons read 0 in the same cycle. After release, the next burst is a full 6 words.
5. With NES_PAD_CHANGE_ONLY_EN, constant buttons 8'h10 → one burst on the first poll. No bursts for the next 29 polls, then a keepalive burst on poll 31. Changing to 8'h20 gives a burst on that same poll.
6. pad_data toggling asynchronously (random phase) with no pad model → no X on any output. axiod upper byte equals lower byte for every valid word.
